pwm_generator: RTL
==================

# pwm_generator

Sixteen-channel output driver that consumes the enable and duty-cycle registers written over SPI and produces the chip's 16 output pins. Each channel is forced low, held statically high, or driven with a shared 8-bit PWM waveform. Duty-cycle changes are double-buffered so that every channel switches glitch-free at a period boundary. The block sits directly downstream of the SPI register file and directly upstream of the output pads.

## Interface
- PRESCALE, 13: clk cycles per PWM step, legal range 1..65535. 10 MHz clk gives 256*13 cycles per period, about 3.0 kHz.
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0
- en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8
- pwm_duty_cycle  input  8  requested duty cycle; 0x00 = 0 %, 0xFF = 100 %
- out  output  16  channel outputs, bit i = channel i
- period_start  output  1  one-cycle pulse marking the first output sample of each PWM period

## Operation
- Enable vectors: en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
- Prescaler presc:
  - Width is clog2(PRESCALE), minimum 1 bit.
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick = (presc == PRESCALE-1).
  - With PRESCALE=1, presc stays at 0 and tick is asserted every cycle.
- Step counter cnt:
  - 8 bits, increments on tick, wraps 255 -> 0.
  - Period = 256*PRESCALE clk cycles.
- Load condition: load = (presc == 0) && (cnt == 0). It is true in the first cycle after reset and in the first cycle of every subsequent period.
- Duty shadow duty_sh:
  - 8 bits, captures pwm_duty_cycle when load is true and holds it otherwise.
  - duty_eff = load ? pwm_duty_cycle : duty_sh.
  - A pwm_duty_cycle change mid-period has no effect until the next load.
- PWM level: pwm_lvl = (duty_eff == 8'hFF) ? 1 : (cnt < duty_eff).
  - High time = duty_eff*PRESCALE cycles per period.
  - 0xFF is a special case: always high.
- Per channel i, next out[i]:
  - en_out[i] == 0: 0. This takes priority regardless of en_pwm.
  - en_out[i] == 1, en_pwm[i] == 0: 1 (static on).
  - en_out[i] == 1, en_pwm[i] == 1: pwm_lvl.
- Enable inputs are not shadowed. Enable changes take effect on the next output sample, even mid-period.
- period_start is asserted, registered, for exactly one cycle per period, following each load cycle.
- Inputs are treated as synchronous to clk; the upstream register file is clocked by clk. No synchronisers.

## Timing
- Reset (asynchronous assert, synchronous release): out = 16'h0000, period_start = 0, presc = 0, cnt = 0, duty_sh = 0.
- All outputs are registered: out and period_start at edge N+1 reflect the inputs and counter values present in cycle N.
- First rising edge after reset release:
  - Samples load = 1.
  - duty_sh takes pwm_duty_cycle.
  - period_start goes high after that edge.
  - out carries the first sample of period 0.
- period_start then repeats every 256*PRESCALE cycles.
- Enable change latency: 1 clk.
- Duty change latency: up to one full period, plus 1 clk, and always aligned to period_start.
- Reset asserted mid-period: out drops to 0 immediately (asynchronous). The counters restart from 0 and no partial period resumes.
- Simultaneous duty change and load: the new value is used for the whole new period. This is the purpose of duty_eff.

## Test plan
- Reset: hold rst_n=0 with all enable inputs at 0xFF. Required: out=0x0000 and period_start=0. After release, period_start pulses once per 3328 clk (PRESCALE=13).
- Static and off: en_out=0x00FF, en_pwm=0x0000. Required: out=0x00FF constantly. Then set en_out=0x0000 with en_pwm=0xFFFF; required: out=0x0000 one clk later.
- PWM 50 %: en_out=en_pwm=0x0001, duty=0x80, PRESCALE=13. Required: out[0] high for exactly 1664 clk starting at period_start, then low for 1664 clk, repeating.
- Extremes:
  - duty=0x00: out[0] never high across 3 periods.
  - duty=0xFF: out[0] never low.
  - duty=0x01: high for exactly 13 clk per period.
- Double buffering: duty=0x40, then change to 0xC0 at cycle 500 of a period. Required: that period is still high for 832 clk; the next period, from period_start, is high for 2496 clk with no runt pulse.
- Mid-period reset: assert rst_n at cycle 1000 with duty=0x80. Required: out=0 at once. After release, period_start occurs on the first edge, and a full 1664-clk high phase follows.

Source files
------------

// File: rtl/pwm_generator.sv
// Sixteen-channel output driver: each pin is forced low, held high, or driven by a
// shared 8-bit PWM whose duty cycle is double-buffered to switch only at period boundaries.
module pwm_generator #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic [7:0]    duty_sh;
  logic [7:0]    duty_eff;
  logic          tick;
  logic          load;
  logic          pwm_lvl;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [15:0]   out_nxt;

  always_comb begin
    en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    tick     = (presc == PRESC_MAX);
    load     = (presc == '0) && (cnt == 8'd0);
    // Bypass the shadow on the load cycle so a duty written in that very cycle
    // governs the whole new period, including its first sample.
    duty_eff = load ? pwm_duty_cycle : duty_sh;
    pwm_lvl  = (duty_eff == 8'hFF) ? 1'b1 : (cnt < duty_eff);
    // Output enable dominates; PWM mode gates the static-on level with pwm_lvl.
    out_nxt  = en_out & (~en_pwm | {16{pwm_lvl}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      cnt          <= 8'd0;
      duty_sh      <= 8'd0;
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + PW'(1);
      cnt          <= tick ? cnt + 8'd1 : cnt;
      duty_sh      <= load ? pwm_duty_cycle : duty_sh;
      out          <= out_nxt;
      period_start <= load;
    end
  end

endmodule
